// File: rtl/mem_wb_writeback.sv
// MEM/WB pipeline register and writeback stage: formats load data, drives the regfile write port, counts retirements.
// Optional HI/LO register pair is built only when MEM_WB_HILO_EN is defined.
module mem_wb_writeback #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              mem_valid,
    input  logic              mem_w_ena,
    input  logic [REG_AW-1:0] mem_w_addr,
    input  logic [DATA_W-1:0] mem_w_data,
    input  logic              mem_load,
    input  logic [2:0]        mem_load_type,
    input  logic [1:0]        mem_addr_lo,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_hi_ena,
    input  logic              mem_lo_ena,
    input  logic [DATA_W-1:0] mem_hi_data,
    input  logic [DATA_W-1:0] mem_lo_data,
    output logic              w_ena,
    output logic [REG_AW-1:0] w_addr,
    output logic [DATA_W-1:0] w_data,
    output logic              wb_valid,
    output logic              misalign_err,
    output logic [CNT_W-1:0]  ret_cnt,
    output logic [DATA_W-1:0] hi_out,
    output logic [DATA_W-1:0] lo_out
);

    localparam logic [2:0] LT_LB  = 3'd0;
    localparam logic [2:0] LT_LBU = 3'd1;
    localparam logic [2:0] LT_LH  = 3'd2;
    localparam logic [2:0] LT_LHU = 3'd3;

    // Big-endian lane select; unknown load types behave as LW.
    function automatic logic [DATA_W-1:0] fmt_load(input logic [DATA_W-1:0] rd,
                                                   input logic [2:0] lt,
                                                   input logic [1:0] lo);
        logic [7:0]  b;
        logic [15:0] h;
        case (lo)
            2'd0:    b = rd[DATA_W-1  -: 8];
            2'd1:    b = rd[DATA_W-9  -: 8];
            2'd2:    b = rd[DATA_W-17 -: 8];
            default: b = rd[DATA_W-25 -: 8];
        endcase
        h = lo[1] ? rd[DATA_W-17 -: 16] : rd[DATA_W-1 -: 16];
        case (lt)
            LT_LB:   fmt_load = {{(DATA_W-8){b[7]}}, b};
            LT_LBU:  fmt_load = {{(DATA_W-8){1'b0}}, b};
            LT_LH:   fmt_load = {{(DATA_W-16){h[15]}}, h};
            LT_LHU:  fmt_load = {{(DATA_W-16){1'b0}}, h};
            default: fmt_load = rd;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [2:0] lt, input logic [1:0] lo);
        case (lt)
            LT_LB, LT_LBU: is_misaligned = 1'b0;
            LT_LH, LT_LHU: is_misaligned = lo[0];
            default:       is_misaligned = (lo != 2'd0);
        endcase
    endfunction

    logic              valid_q, valid_d;
    logic              we_q, we_d;
    logic [REG_AW-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              mis_q, mis_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              mis_c;
    logic              we_c;
    logic [DATA_W-1:0] data_c;

    always_comb begin
        mis_c  = mem_valid & mem_load & is_misaligned(mem_load_type, mem_addr_lo);
        we_c   = mem_valid & mem_w_ena & (mem_w_addr != '0) & ~mis_c;
        data_c = mem_load ? fmt_load(mem_rdata, mem_load_type, mem_addr_lo) : mem_w_data;
    end

    // Flush beats stall; a stalled slot holds but never repeats its misalign pulse.
    always_comb begin
        valid_d = valid_q;
        we_d    = we_q;
        addr_d  = addr_q;
        data_d  = data_q;
        mis_d   = 1'b0;
        cnt_d   = cnt_q;
        if (flush) begin
            valid_d = 1'b0;
            we_d    = 1'b0;
            addr_d  = '0;
            data_d  = '0;
        end else if (!stall) begin
            valid_d = mem_valid;
            we_d    = we_c;
            addr_d  = we_c ? mem_w_addr : '0;
            data_d  = we_c ? data_c : '0;
            mis_d   = mis_c;
            cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, mem_valid};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            mis_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            mis_q   <= mis_d;
            cnt_q   <= cnt_d;
        end
    end

    assign w_ena        = we_q;
    assign w_addr       = addr_q;
    assign w_data       = data_q;
    assign wb_valid     = valid_q;
    assign misalign_err = mis_q;
    assign ret_cnt      = cnt_q;

`ifdef MEM_WB_HILO_EN
    logic              hi_en_q, hi_en_d, lo_en_q, lo_en_d;
    logic [DATA_W-1:0] hi_pend_q, hi_pend_d, lo_pend_q, lo_pend_d;
    logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d;

    // Pending slot commits only when it is allowed to advance; flush discards it.
    always_comb begin
        hi_en_d   = hi_en_q;
        lo_en_d   = lo_en_q;
        hi_pend_d = hi_pend_q;
        lo_pend_d = lo_pend_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        if (valid_q && !stall && !flush) begin
            if (hi_en_q) hi_d = hi_pend_q;
            if (lo_en_q) lo_d = lo_pend_q;
        end
        if (flush) begin
            hi_en_d = 1'b0;
            lo_en_d = 1'b0;
        end else if (!stall) begin
            hi_en_d   = mem_valid & mem_hi_ena;
            lo_en_d   = mem_valid & mem_lo_ena;
            hi_pend_d = mem_hi_data;
            lo_pend_d = mem_lo_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_en_q   <= 1'b0;
            lo_en_q   <= 1'b0;
            hi_pend_q <= '0;
            lo_pend_q <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            hi_en_q   <= hi_en_d;
            lo_en_q   <= lo_en_d;
            hi_pend_q <= hi_pend_d;
            lo_pend_q <= lo_pend_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign hi_out = (valid_q && hi_en_q) ? hi_pend_q : hi_q;
    assign lo_out = (valid_q && lo_en_q) ? lo_pend_q : lo_q;
`else
    logic unused_hilo;
    assign unused_hilo = ^{mem_hi_ena, mem_lo_ena, mem_hi_data, mem_lo_data};
    assign hi_out = '0;
    assign lo_out = '0;
`endif

endmodule

// File: tb/tb_mem_wb_writeback.sv
// Directed bench for mem_wb_writeback: vector table for single-cycle formatting plus
// hand sequences for stall, flush, misalign, reset and HI/LO (MEM_WB_HILO_EN).
module tb_mem_wb_writeback;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, flush;
    logic        mem_valid, mem_w_ena, mem_load;
    logic [4:0]  mem_w_addr;
    logic [31:0] mem_w_data, mem_rdata;
    logic [2:0]  mem_load_type;
    logic [1:0]  mem_addr_lo;
    logic        mem_hi_ena, mem_lo_ena;
    logic [31:0] mem_hi_data, mem_lo_data;
    logic        w_ena, wb_valid, misalign_err;
    logic [4:0]  w_addr;
    logic [31:0] w_data, ret_cnt, hi_out, lo_out;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    mem_wb_writeback dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .mem_valid(mem_valid), .mem_w_ena(mem_w_ena), .mem_w_addr(mem_w_addr),
        .mem_w_data(mem_w_data), .mem_load(mem_load), .mem_load_type(mem_load_type),
        .mem_addr_lo(mem_addr_lo), .mem_rdata(mem_rdata),
        .mem_hi_ena(mem_hi_ena), .mem_lo_ena(mem_lo_ena),
        .mem_hi_data(mem_hi_data), .mem_lo_data(mem_lo_data),
        .w_ena(w_ena), .w_addr(w_addr), .w_data(w_data), .wb_valid(wb_valid),
        .misalign_err(misalign_err), .ret_cnt(ret_cnt), .hi_out(hi_out), .lo_out(lo_out)
    );

    typedef struct {
        logic        v, we, ld;
        logic [4:0]  a;
        logic [31:0] wd;
        logic [2:0]  lt;
        logic [1:0]  lo;
        logic [31:0] rd;
        logic        e_we;
        logic [4:0]  e_a;
        logic [31:0] e_d;
        logic        e_vld, e_mis;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs[NV];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic we, input logic [4:0] a, input logic [31:0] wd,
                         input logic ld, input logic [2:0] lt, input logic [1:0] lo,
                         input logic [31:0] rd);
        mem_valid = v; mem_w_ena = we; mem_w_addr = a; mem_w_data = wd;
        mem_load = ld; mem_load_type = lt; mem_addr_lo = lo; mem_rdata = rd;
    endtask

    task automatic chk_slot(input string nm, input logic e_we, input logic [4:0] e_a,
                            input logic [31:0] e_d, input logic e_vld, input logic e_mis);
        chk({nm, ".w_ena"}, {31'd0, w_ena}, {31'd0, e_we});
        chk({nm, ".w_addr"}, {27'd0, w_addr}, {27'd0, e_a});
        chk({nm, ".w_data"}, w_data, e_d);
        chk({nm, ".wb_valid"}, {31'd0, wb_valid}, {31'd0, e_vld});
        chk({nm, ".misalign"}, {31'd0, misalign_err}, {31'd0, e_mis});
        chk({nm, ".ret_cnt"}, ret_cnt, exp_cnt);
    endtask

    initial begin
        //            v   we  ld  a    wd            lt  lo  rd             e_we e_a  e_d           vld mis
        vecs[0]  = '{1'b1,1'b1,1'b0,5'd5, 32'h00001234,3'd0,2'd0,32'h0,       1'b1,5'd5, 32'h00001234,1'b1,1'b0};
        vecs[1]  = '{1'b1,1'b1,1'b1,5'd3, 32'hAAAAAAAA,3'd0,2'd0,32'h80FF1234,1'b1,5'd3, 32'hFFFFFF80,1'b1,1'b0};
        vecs[2]  = '{1'b1,1'b1,1'b1,5'd3, 32'hAAAAAAAA,3'd1,2'd1,32'h80FF1234,1'b1,5'd3, 32'h000000FF,1'b1,1'b0};
        vecs[3]  = '{1'b1,1'b1,1'b1,5'd3, 32'hAAAAAAAA,3'd2,2'd2,32'h80FF1234,1'b1,5'd3, 32'h00001234,1'b1,1'b0};
        vecs[4]  = '{1'b1,1'b1,1'b1,5'd3, 32'hAAAAAAAA,3'd4,2'd0,32'h80FF1234,1'b1,5'd3, 32'h80FF1234,1'b1,1'b0};
        vecs[5]  = '{1'b1,1'b1,1'b1,5'd6, 32'hAAAAAAAA,3'd3,2'd0,32'h80FF1234,1'b1,5'd6, 32'h000080FF,1'b1,1'b0};
        vecs[6]  = '{1'b1,1'b1,1'b1,5'd6, 32'hAAAAAAAA,3'd0,2'd3,32'h80FF1234,1'b1,5'd6, 32'h00000034,1'b1,1'b0};
        vecs[7]  = '{1'b1,1'b1,1'b1,5'd6, 32'hAAAAAAAA,3'd1,2'd2,32'h80FF1234,1'b1,5'd6, 32'h00000012,1'b1,1'b0};
        vecs[8]  = '{1'b1,1'b1,1'b1,5'd6, 32'hAAAAAAAA,3'd2,2'd0,32'h80FF1234,1'b1,5'd6, 32'hFFFF80FF,1'b1,1'b0};
        vecs[9]  = '{1'b1,1'b1,1'b0,5'd0, 32'h0000BEEF,3'd0,2'd0,32'h0,       1'b0,5'd0, 32'h00000000,1'b1,1'b0};
        vecs[10] = '{1'b1,1'b1,1'b1,5'd7, 32'hAAAAAAAA,3'd4,2'd2,32'h80FF1234,1'b0,5'd0, 32'h00000000,1'b1,1'b1};
        vecs[11] = '{1'b1,1'b1,1'b1,5'd7, 32'hAAAAAAAA,3'd2,2'd1,32'h80FF1234,1'b0,5'd0, 32'h00000000,1'b1,1'b1};
        vecs[12] = '{1'b0,1'b1,1'b0,5'd7, 32'h11111111,3'd0,2'd0,32'h0,       1'b0,5'd0, 32'h00000000,1'b0,1'b0};
        vecs[13] = '{1'b1,1'b0,1'b0,5'd7, 32'h22222222,3'd0,2'd0,32'h0,       1'b0,5'd0, 32'h00000000,1'b1,1'b0};
        vecs[14] = '{1'b1,1'b1,1'b1,5'd8, 32'hAAAAAAAA,3'd6,2'd0,32'h80FF1234,1'b1,5'd8, 32'h80FF1234,1'b1,1'b0};
        vecs[15] = '{1'b1,1'b1,1'b1,5'd8, 32'hAAAAAAAA,3'd7,2'd1,32'h80FF1234,1'b0,5'd0, 32'h00000000,1'b1,1'b1};
        vecs[16] = '{1'b1,1'b1,1'b1,5'd9, 32'hAAAAAAAA,3'd3,2'd2,32'h80FF1234,1'b1,5'd9, 32'h00001234,1'b1,1'b0};

        rst = 1'b0; stall = 1'b0; flush = 1'b0;
        mem_hi_ena = 1'b0; mem_lo_ena = 1'b0; mem_hi_data = '0; mem_lo_data = '0;
        drive(1'b1, 1'b1, 5'd4, 32'h5555AAAA, 1'b0, 3'd0, 2'd0, 32'h0);
        tick(); tick();
        chk_slot("reset", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        chk("reset.hi_out", hi_out, 32'h0);
        chk("reset.lo_out", lo_out, 32'h0);
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 3'd0, 2'd0, 32'h0);
        rst = 1'b1;
        tick();
        chk_slot("idle", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].v, vecs[i].we, vecs[i].a, vecs[i].wd, vecs[i].ld, vecs[i].lt,
                  vecs[i].lo, vecs[i].rd);
            tick();
            if (vecs[i].v) exp_cnt++;
            chk_slot($sformatf("vec%0d", i), vecs[i].e_we, vecs[i].e_a, vecs[i].e_d,
                     vecs[i].e_vld, vecs[i].e_mis);
        end

        // Stall for three cycles: slot and counter frozen.
        drive(1'b1, 1'b1, 5'd9, 32'h00000055, 1'b0, 3'd0, 2'd0, 32'h0);
        tick(); exp_cnt++;
        chk_slot("stall.pre", 1'b1, 5'd9, 32'h55, 1'b1, 1'b0);
        stall = 1'b1;
        drive(1'b1, 1'b1, 5'd10, 32'h00000066, 1'b0, 3'd0, 2'd0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_slot($sformatf("stall%0d", k), 1'b1, 5'd9, 32'h55, 1'b1, 1'b0);
        end
        stall = 1'b0;
        tick(); exp_cnt++;
        chk_slot("stall.release", 1'b1, 5'd10, 32'h66, 1'b1, 1'b0);

        // Misalign pulse is one cycle even when the slot is held by stall.
        drive(1'b1, 1'b1, 5'd4, 32'h0, 1'b1, 3'd4, 2'd2, 32'h80FF1234);
        tick(); exp_cnt++;
        chk_slot("mis.cap", 1'b0, 5'd0, 32'h0, 1'b1, 1'b1);
        stall = 1'b1;
        tick();
        chk_slot("mis.stall", 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
        stall = 1'b0;
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 3'd0, 2'd0, 32'h0);
        tick();
        chk_slot("mis.after", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);

        // Flush together with stall inserts a bubble.
        drive(1'b1, 1'b1, 5'd11, 32'h00000077, 1'b0, 3'd0, 2'd0, 32'h0);
        tick(); exp_cnt++;
        chk_slot("flush.pre", 1'b1, 5'd11, 32'h77, 1'b1, 1'b0);
        stall = 1'b1; flush = 1'b1;
        tick();
        chk_slot("flush.bubble", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        stall = 1'b0; flush = 1'b0;
        tick(); exp_cnt++;
        chk_slot("flush.resume", 1'b1, 5'd11, 32'h77, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 3'd0, 2'd0, 32'h0);
        tick();

`ifdef MEM_WB_HILO_EN
        mem_valid = 1'b1; mem_hi_ena = 1'b1; mem_hi_data = 32'hDEADBEEF;
        tick(); exp_cnt++;
        chk("hilo.bypass", hi_out, 32'hDEADBEEF);
        mem_valid = 1'b0; mem_hi_ena = 1'b0; mem_hi_data = 32'h0;
        tick();
        chk("hilo.commit", hi_out, 32'hDEADBEEF);
        tick();
        chk("hilo.retain", hi_out, 32'hDEADBEEF);
        mem_valid = 1'b1; mem_lo_ena = 1'b1; mem_lo_data = 32'hCAFEF00D;
        tick(); exp_cnt++;
        chk("hilo.lo_bypass", lo_out, 32'hCAFEF00D);
        chk("hilo.hi_kept", hi_out, 32'hDEADBEEF);
        mem_lo_ena = 1'b0; mem_hi_ena = 1'b1; mem_hi_data = 32'h12345678;
        tick(); exp_cnt++;
        chk("hilo.pend2", hi_out, 32'h12345678);
        mem_valid = 1'b0; mem_hi_ena = 1'b0; flush = 1'b1;
        tick();
        chk("hilo.flush_kill", hi_out, 32'hDEADBEEF);
        flush = 1'b0;
        tick();
        chk("hilo.after_flush", hi_out, 32'hDEADBEEF);
        chk("hilo.lo_commit", lo_out, 32'hCAFEF00D);
        mem_valid = 1'b1; mem_hi_ena = 1'b1; mem_hi_data = 32'h0BADF00D;
        tick(); exp_cnt++;
        mem_valid = 1'b0; mem_hi_ena = 1'b0; stall = 1'b1;
        tick();
        chk("hilo.stall_pend", hi_out, 32'h0BADF00D);
        stall = 1'b0;
        tick();
        chk("hilo.stall_commit", hi_out, 32'h0BADF00D);
`else
        mem_valid = 1'b1; mem_hi_ena = 1'b1; mem_lo_ena = 1'b1;
        mem_hi_data = 32'hDEADBEEF; mem_lo_data = 32'hCAFEF00D;
        tick(); exp_cnt++;
        chk("nohilo.hi", hi_out, 32'h0);
        chk("nohilo.lo", lo_out, 32'h0);
        mem_valid = 1'b0; mem_hi_ena = 1'b0; mem_lo_ena = 1'b0;
        tick();
        chk("nohilo.hi2", hi_out, 32'h0);
        chk("nohilo.lo2", lo_out, 32'h0);
`endif
        chk("cnt.total", ret_cnt, exp_cnt);

        // Asynchronous reset mid-operation clears immediately.
        drive(1'b1, 1'b1, 5'd12, 32'h000000AB, 1'b0, 3'd0, 2'd0, 32'h0);
        tick(); exp_cnt++;
        chk_slot("rst.pre", 1'b1, 5'd12, 32'hAB, 1'b1, 1'b0);
        #2 rst = 1'b0;
        #1;
        exp_cnt = 0;
        chk_slot("rst.async", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        chk("rst.hi_out", hi_out, 32'h0);
        chk("rst.lo_out", lo_out, 32'h0);
        tick();
        chk_slot("rst.held", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        rst = 1'b1;
        drive(1'b1, 1'b1, 5'd13, 32'h000000CD, 1'b0, 3'd0, 2'd0, 32'h0);
        tick(); exp_cnt++;
        chk_slot("rst.first", 1'b1, 5'd13, 32'hCD, 1'b1, 1'b0);
        chk("rst.cnt_one", ret_cnt, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_wb_writeback.md
Name: mem_wb_writeback

Overview:
- MEM/WB pipeline register plus writeback stage; drives the regfile write port (the consumer side of the regfile read ports used by ID).
- Captures MEM-stage results and formats load data from the data RAM.
- Presents one registered write per cycle to regfile, and the same signals to ID as the bypass source.
- Maintains a retired-instruction counter and an optional HI/LO register pair.

Parameters:
- DATA_W, 32, datapath width
- REG_AW, 5, register address width
- CNT_W, 32, retire counter width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- stall  in  1  hold stage contents
- flush  in  1  insert bubble; overrides stall
- mem_valid  in  1  MEM slot holds a real instruction
- mem_w_ena  in  1  instruction writes a GPR
- mem_w_addr  in  REG_AW  destination GPR
- mem_w_data  in  DATA_W  ALU result (non-load)
- mem_load  in  1  instruction is a load
- mem_load_type  in  3  0=LB 1=LBU 2=LH 3=LHU 4=LW, others=LW
- mem_addr_lo  in  2  effective address bits [1:0]
- mem_rdata  in  DATA_W  data RAM word, valid same cycle
- mem_hi_ena, mem_lo_ena  in  1 each  HI/LO write request
- mem_hi_data, mem_lo_data  in  DATA_W each  HI/LO write values
- w_ena  out  1  regfile write enable
- w_addr  out  REG_AW  regfile write address
- w_data  out  DATA_W  regfile write data
- wb_valid  out  1  WB slot holds a real instruction
- misalign_err  out  1  one-cycle pulse, misaligned load dropped
- ret_cnt  out  CNT_W  retired instruction count
- hi_out, lo_out  out  DATA_W each  architectural HI/LO, bypassed

Behaviour:
- Reset (rst=0, async): all outputs 0, including the counter and HI/LO.
- Update on posedge clk only; priority is flush > stall > load.
  - flush=1: bubble; wb_valid/w_ena/w_addr/w_data/misalign_err all 0.
  - stall=1 (flush=0): all stage registers hold; misalign_err forced 0.
  - Otherwise: capture MEM inputs; results are visible 1 cycle after MEM.
- Load formatting (combinational before capture, big-endian):
  - Byte lane: addr_lo 0 -> bits [31:24], 1 -> [23:16], 2 -> [15:8], 3 -> [7:0].
  - Halfword: addr_lo 0 -> bits [31:16], 2 -> [15:0].
  - LB/LH sign-extend; LBU/LHU zero-extend.
- Misalignment:
  - Defined as LH/LHU with addr_lo[0]=1, or LW with addr_lo!=0.
  - Effect: captured w_ena=0, misalign_err=1 for exactly one cycle, wb_valid still 1.
- w_ena = mem_valid & mem_w_ena & (mem_w_addr!=0) & !misaligned; when w_ena=0 the slot's w_addr/w_data are driven 0.
- ret_cnt:
  - +1 on every posedge where the newly captured slot has mem_valid=1 (not stall, not flush).
  - Wraps modulo 2^CNT_W, no saturation.
- Reset mid-operation: immediate clear, no partial write emitted.

Optional Feature:
- Macro: MEM_WB_HILO_EN.
- Defined:
  - HI/LO requests captured with the slot, committed to architectural HI/LO on the following posedge if wb_valid=1 and not stalled.
  - hi_out/lo_out bypass the pending WB-slot value while it awaits commit.
  - A flush kills an uncommitted HI/LO write.
- Undefined: HI/LO inputs ignored; hi_out/lo_out constant 0; no HI/LO storage synthesized.

Test Plan:
- Reset: rst=0 during activity -> all outputs 0 immediately; after release, first valid instruction gives ret_cnt=1.
- ALU write: mem_valid=1, w_ena=1, addr=5, data=0x00001234 -> next cycle w_ena=1, w_addr=5, w_data=0x00001234, wb_valid=1.
- Loads with rdata=0x80FF1234:
  - LB, addr_lo=0 -> 0xFFFFFF80
  - LBU, addr_lo=1 -> 0x000000FF
  - LH, addr_lo=2 -> 0x00001234
  - LW -> 0x80FF1234
- r0 / misalign:
  - Write to addr 0 -> w_ena=0, ret_cnt still increments.
  - LW with addr_lo=2 -> w_ena=0, misalign_err high exactly 1 cycle.
- Stall/flush:
  - stall=1 for 3 cycles -> outputs frozen, ret_cnt unchanged.
  - flush=1 with stall=1 -> bubble next cycle.
- MEM_WB_HILO_EN defined:
  - mem_hi_ena=1, hi_data=0xDEADBEEF -> hi_out=0xDEADBEEF one cycle after capture (bypass), retained afterward.
  - Flush before commit -> hi_out reverts to previous value.
